// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic datapath: default sizes,
// index-width helper and the tap feeder state encoding.
package da_pkg;

    localparam int unsigned DA_DW   = 8;
    localparam int unsigned DA_TAPS = 4;

    function automatic int unsigned idx_width(input int unsigned dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int unsigned DA_IW = idx_width(DA_DW);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } da_state_e;

endpackage

// File: rtl/da_tap_shreg.sv
// Parallel-load, right-shift register for one tap; exposes the bit that will
// be presented next.
module da_tap_shreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         lsb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/da_tap_feeder.sv
// Sample delay line feeding a DA core bit-serially: one TAPS-wide address
// slice per cycle, LSB first, DW cycles per accepted sample.
module da_tap_feeder
    import da_pkg::*;
#(
    parameter int unsigned DW   = DA_DW,
    parameter int unsigned TAPS = DA_TAPS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_data,
    output logic [TAPS-1:0]          x_bits,
    output logic                     x_valid,
    output logic                     x_first,
    output logic                     x_last,
    output logic [idx_width(DW)-1:0] x_idx
);

    localparam int unsigned IW = idx_width(DW);
    localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);

    da_state_e       state;
    logic [DW-1:0]   taps     [TAPS];
    logic [DW-1:0]   tap_nxt  [TAPS];
    logic [TAPS-1:0] sh_lsb;
    logic [TAPS-1:0] bits_first;
    logic [TAPS-1:0] bits_next;
    logic            at_last;
    logic            accept;
    logic            shift_en;

    assign at_last  = (x_idx == LAST_IDX);
    assign s_ready  = !clear && ((state == IDLE) || at_last);
    assign accept   = s_valid && s_ready;
    assign shift_en = (state == SHIFT) && !at_last && !clear;

    // Delay-line contents after an accept, plus the address slices
    // (tap1 lands in the MSB of x_bits).
    always_comb begin
        bits_first = '0;
        bits_next  = '0;
        tap_nxt[0] = s_data;
        for (int i = 1; i < int'(TAPS); i++) begin
            tap_nxt[i] = taps[i-1];
        end
        for (int i = 0; i < int'(TAPS); i++) begin
            bits_first[int'(TAPS) - 1 - i] = tap_nxt[i][0];
            bits_next[int'(TAPS) - 1 - i]  = sh_lsb[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TAPS); i++) taps[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(TAPS); i++) taps[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < int'(TAPS); i++) taps[i] <= tap_nxt[i];
        end
    end

    // Bit 0 goes straight to x_bits on accept, so shadows hold the word from bit 1 up.
    for (genvar g = 0; g < int'(TAPS); g++) begin : g_tap
        da_tap_shreg #(
            .W (DW)
        ) u_shreg (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .load  (accept),
            .shift (shift_en),
            .din   (tap_nxt[g] >> 1),
            .lsb   (sh_lsb[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x_idx   <= '0;
            x_valid <= 1'b0;
            x_first <= 1'b0;
            x_last  <= 1'b0;
            x_bits  <= '0;
        end else if (clear) begin
            state   <= IDLE;
            x_idx   <= '0;
            x_valid <= 1'b0;
            x_first <= 1'b0;
            x_last  <= 1'b0;
            x_bits  <= '0;
        end else if (accept) begin
            state   <= SHIFT;
            x_idx   <= '0;
            x_valid <= 1'b1;
            x_first <= 1'b1;
            x_last  <= 1'b0;
            x_bits  <= bits_first;
        end else if (state == SHIFT) begin
            if (at_last) begin
                state   <= IDLE;
                x_idx   <= '0;
                x_valid <= 1'b0;
                x_first <= 1'b0;
                x_last  <= 1'b0;
                x_bits  <= '0;
            end else begin
                x_idx   <= x_idx + IW'(1);
                x_first <= 1'b0;
                x_last  <= (x_idx == IW'(DW - 2));
                x_bits  <= bits_next;
            end
        end
    end

endmodule

// File: tb/tb_da_tap_feeder.sv
// Directed bench for da_tap_feeder with a frame-level reference model checked
// every cycle.
module tb_da_tap_feeder;

    localparam int DW   = 8;
    localparam int TAPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic [3:0] x_bits;
    logic       x_valid;
    logic       x_first;
    logic       x_last;
    logic [2:0] x_idx;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    da_tap_feeder #(.DW(DW), .TAPS(TAPS)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .x_bits  (x_bits),
        .x_valid (x_valid),
        .x_first (x_first),
        .x_last  (x_last),
        .x_idx   (x_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: history of accepted samples and position in the current frame.
    logic [7:0] hist [$];
    logic [7:0] frame [TAPS];
    int         pos = -1;

    initial begin
        for (int i = 0; i < TAPS; i++) frame[i] = 8'h00;
        forever begin
            @(posedge clk or posedge rst);
            if (rst || clear) begin
                hist.delete();
                pos = -1;
            end else if (s_valid && (pos < 0 || pos == DW - 1)) begin
                hist.push_front(s_data);
                if (hist.size() > TAPS) void'(hist.pop_back());
                for (int i = 0; i < TAPS; i++)
                    frame[i] = (i < hist.size()) ? hist[i] : 8'h00;
                pos = 0;
            end else if (pos >= 0) begin
                pos = (pos == DW - 1) ? -1 : pos + 1;
            end
        end
    end

    initial begin
        logic [3:0] eb;
        logic       ev;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ev = (pos >= 0);
                eb = 4'h0;
                if (ev) for (int i = 0; i < TAPS; i++) eb[TAPS-1-i] = frame[i][pos];
                check("mdl_s_ready", 32'(s_ready), 32'(!clear && (pos < 0 || pos == DW - 1)));
                check("mdl_x_valid", 32'(x_valid), 32'(ev));
                check("mdl_x_bits",  32'(x_bits),  32'(eb));
                check("mdl_x_first", 32'(x_first), 32'(ev && pos == 0));
                check("mdl_x_last",  32'(x_last),  32'(ev && pos == DW - 1));
                if (ev) check("mdl_x_idx", 32'(x_idx), 32'(pos));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Offer a sample until accepted; returns at posedge+1 of the bit-0 cycle.
    task automatic send(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
        end
        if (!ok) begin
            fails++;
            tests++;
            $display("FAIL send_timeout: got no s_ready, expected s_ready=1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (!x_valid) ok = 1'b1;
        end
        if (!ok) begin
            fails++;
            tests++;
            $display("FAIL idle_timeout: got x_valid=1, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] col, fv, lv, vv;
        logic [2:0] low;
        logic [7:0] d3 [3];
        int acc, run, maxrun, wraps, bad, vcnt;
        bit prev_v, r, done;
        logic [2:0] prev_idx;

        // Reset values
        #7;
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_x_bits",  32'(x_bits),  32'd0);
        check("rst_x_idx",   32'(x_idx),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_release_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Single sample 0x81 into an empty line
        send(8'h81);
        col = '0; fv = '0; lv = '0; vv = '0; low = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            col[k] = x_bits[3];
            low |= x_bits[2:0];
            fv[k] = x_first;
            lv[k] = x_last;
            vv[k] = x_valid;
        end
        check("f81_tap1_bits", 32'(col), 32'h81);
        check("f81_older_zero", 32'(low), 32'h0);
        check("f81_first", 32'(fv), 32'h01);
        check("f81_last",  32'(lv), 32'h80);
        check("f81_valid", 32'(vv), 32'hFF);
        @(negedge clk);
        check("f81_end_valid", 32'(x_valid), 32'd0);
        @(posedge clk); #1;

        // Four samples fill the line
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        @(negedge clk);
        check("fill_idx0", 32'(x_bits), 32'h5);
        @(posedge clk); #1;
        @(negedge clk);
        check("fill_idx1", 32'(x_bits), 32'h6);
        @(posedge clk); #1;
        @(negedge clk);
        check("fill_idx2", 32'(x_bits), 32'h8);
        wait_idle();

        // Back-to-back frames with s_valid held high
        d3[0] = 8'h11; d3[1] = 8'hA5; d3[2] = 8'h3C;
        acc = 0; run = 0; maxrun = 0; wraps = 0; bad = 0;
        prev_v = 1'b0; prev_idx = 3'd0; done = 1'b0;
        s_valid = 1'b1;
        s_data  = d3[0];
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            run = x_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (x_valid && prev_v && prev_idx == 3'd7 && x_idx == 3'd0) wraps++;
            if (x_valid && (s_ready != (x_idx == 3'd7))) bad++;
            prev_v = x_valid;
            prev_idx = x_idx;
            r = s_ready;
            if (acc == 3 && !x_valid && maxrun > 0) done = 1'b1;
            @(posedge clk); #1;
            if (r && s_valid) begin
                acc++;
                if (acc == 3) s_valid = 1'b0;
                else s_data = d3[acc];
            end
        end
        check("b2b_done",    32'(done),   32'd1);
        check("b2b_accepts", 32'(acc),    32'd3);
        check("b2b_run",     32'(maxrun), 32'd24);
        check("b2b_wraps",   32'(wraps),  32'd2);
        check("b2b_ready",   32'(bad),    32'd0);

        // s_valid pulse mid-frame is ignored
        send(8'h5A);
        repeat (3) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = 8'hFF;
        @(negedge clk);
        check("mid_s_ready", 32'(s_ready), 32'd0);
        check("mid_idx",     32'(x_idx),   32'd3);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("mid_next_idx", 32'(x_idx), 32'd4);
        repeat (4) @(negedge clk);
        check("mid_no_extra_frame", 32'(x_valid), 32'd0);
        @(posedge clk); #1;

        // clear at x_idx 4 beats a simultaneous s_valid
        send(8'h33);
        repeat (4) begin @(posedge clk); #1; end
        clear = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h44;
        @(negedge clk);
        check("clr_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("clr_x_valid", 32'(x_valid), 32'd0);
        check("clr_x_bits",  32'(x_bits),  32'd0);
        @(posedge clk); #1;
        send(8'h7F);
        col = '0; low = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            col[k] = x_bits[3];
            low |= x_bits[2:0];
        end
        check("clr_7f_tap1",  32'(col), 32'h7F);
        check("clr_7f_older", 32'(low), 32'h0);
        wait_idle();

        // Asynchronous reset mid-frame
        send(8'hC3);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("arst_x_valid", 32'(x_valid), 32'd0);
        check("arst_x_bits",  32'(x_bits),  32'd0);
        check("arst_x_first", 32'(x_first), 32'd0);
        check("arst_x_last",  32'(x_last),  32'd0);
        check("arst_x_idx",   32'(x_idx),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("arst_s_ready", 32'(s_ready), 32'd1);
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (x_valid) vcnt++;
        end
        check("arst_no_residual", 32'(vcnt), 32'd0);
        @(posedge clk); #1;
        send(8'h0F);
        @(negedge clk);
        check("arst_new_frame", 32'(x_bits), 32'h8);
        wait_idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/da_tap_feeder.md
DA_TAP_FEEDER -- requirements
Module: da_tap_feeder

Interface
REQ-001 SHALL have parameter DW, default 8, sample width in bits.
REQ-002 SHALL have parameter TAPS, default 4, delay-line depth (one DA address bit per tap).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous flush of delay line and frame.
REQ-006 SHALL have port s_valid  input  1  upstream sample valid.
REQ-007 SHALL have port s_ready  output  1  feeder can accept a sample this cycle.
REQ-008 SHALL have port s_data  input  DW  signed two's-complement sample.
REQ-009 SHALL have port x_bits  output  TAPS  bit k of taps 1..TAPS; x_bits[TAPS-1]=tap1 (newest) ... x_bits[0]=tapTAPS (oldest), i.e. {X1,X2,X3,X4} address order.
REQ-010 SHALL have port x_valid  output  1  x_bits valid this cycle.
REQ-011 SHALL have port x_first  output  1  marks bit 0 (LSB) of a frame.
REQ-012 SHALL have port x_last  output  1  marks bit DW-1 (sign bit; consumer subtracts).
REQ-013 SHALL have port x_idx  output  clog2(DW)  current bit index k.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-015 SHALL drive s_ready=1 in IDLE, and in SHIFT only when x_idx==DW-1; s_ready SHALL be 0 whenever clear=1.
REQ-016 SHALL, on s_valid&&s_ready at an edge, shift the delay line (tap1<=s_data, tapN<=tapN-1, oldest discarded) and load a shadow shift register per tap with the new tap contents.
REQ-017 SHALL present bit 0 of the accepted frame on the cycle after the accepting edge (latency 1), then bits 1..DW-1 on consecutive cycles, LSB first, with no gaps.
REQ-018 SHALL hold x_valid=1 for exactly DW cycles per frame; x_first=1 only at x_idx==0, x_last=1 only at x_idx==DW-1.
REQ-019 SHALL transition IDLE->SHIFT on accept; SHIFT->SHIFT on accept at x_idx==DW-1 (back-to-back, x_idx wraps DW-1->0); SHIFT->IDLE at x_idx==DW-1 without accept.
REQ-020 SHALL sustain throughput of one sample per DW cycles with continuous x_valid when s_valid is held high.
REQ-021 SHALL not accept s_valid while in SHIFT with x_idx<DW-1; data on s_data SHALL be ignored until s_ready.
REQ-022 SHALL treat taps not yet written since reset/clear as zero (priming: first TAPS-1 frames carry zero older taps).
REQ-023 SHALL, on clear=1, zero delay line and shadow registers, go IDLE, and drive x_valid/x_first/x_last=0 from the next cycle; clear wins over a simultaneous s_valid.
REQ-024 SHALL register all outputs except s_ready (combinational from state, x_idx, clear).
REQ-025 SHALL drive x_bits=0 whenever x_valid=0.

Reset
REQ-026 SHALL, on rst=1, immediately force state=IDLE, delay line and shadow registers=0, x_bits=0, x_valid=0, x_first=0, x_last=0, x_idx=0, independent of clk.
REQ-027 SHALL abandon any in-progress frame on reset with no partial output after rst deasserts.
REQ-028 SHALL assert s_ready=1 in the first cycle after rst deasserts (clear=0).

Structure
REQ-029 SHALL take DW, TAPS, index width and the FSM state enum from shared package da_pkg, shared with the DA core.
REQ-030 SHALL instantiate one sub-module da_tap_shreg (parallel-load, right-shift DW-bit register) per tap; the delay line stays in the top.

Verification
REQ-031 SHALL cover: reset, accept 0x81 -> x_bits[3] sequence 1,0,0,0,0,0,0,1 over 8 cycles, x_bits[2:0]=0, x_first at cycle 1, x_last at cycle 8.
REQ-032 SHALL cover: samples 0x01,0x02,0x03,0x04 -> during frame 4 at x_idx=0 x_bits=4'b0101, at x_idx=1 x_bits=4'b0110, at x_idx=2 x_bits=4'b1000.
REQ-033 SHALL cover: s_valid held high with 3 samples -> x_valid high 24 consecutive cycles, x_idx wraps 7->0 twice, s_ready high only at x_idx==7.
REQ-034 SHALL cover: s_valid pulsed at x_idx==3 -> not accepted, s_ready=0, frame continues unchanged.
REQ-035 SHALL cover: clear at x_idx==4 with s_valid=1 -> x_valid=0 next cycle, no accept; next sample 0x7F frame shows taps 2..4 as zero.
REQ-036 SHALL cover: rst asserted mid-frame between clock edges -> outputs zero immediately; after release, s_ready=1 and no residual frame bits.
